// File: rtl/whack_scorer.sv
`default_nettype none
// ============================================================================
// Module  : whack_scorer
// Brief   : Hit/miss judge for each mole screen; keeps BCD score/top score and
//           writes results to game_mem.
// Revision: 1.0  initial release
// ============================================================================
module whack_scorer #(
    parameter int WINDOW_CYCLES   = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state,
    input  logic       hit_key,
    output logic [7:0] score,
    output logic [7:0] top_score,
    output logic [4:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       mem_wren,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       mole_done
);

    localparam int c_WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int c_DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_WIN_W-1:0] c_WIN_LOAD = c_WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] c_CODE_START = 3'b000;
    localparam logic [2:0] c_CODE_MOLE1 = 3'b010;
    localparam logic [2:0] c_CODE_MOLE4 = 3'b101;
    localparam logic [2:0] c_CODE_OVER  = 3'b110;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ARMED   = 3'd1;
    localparam logic [2:0] c_WRITE   = 3'd2;
    localparam logic [2:0] c_DONE    = 3'd3;
    localparam logic [2:0] c_OVER_WR = 3'd4;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_db_level;
    logic              r_db_prev;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              w_press;

    logic [2:0]         r_prev_state;
    logic [2:0]         r_fsm;
    logic [2:0]         w_fsm_next;
    logic [2:0]         r_mole_code;
    logic [c_WIN_W-1:0] r_win_cnt;
    logic [7:0]         r_score;
    logic [7:0]         r_top_score;
    logic [4:0]         r_mem_addr;
    logic [7:0]         r_mem_data;

    logic       w_entry;
    logic       w_is_mole;
    logic       w_hit;
    logic       w_miss;
    logic       w_load_win;
    logic       w_clear_score;
    logic       w_start_over;
    logic [7:0] w_score_inc;
    logic [7:0] w_score_next;

    // Raw key is asynchronous: two flops, then a level that flips only after
    // the synchronised value has disagreed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sync1   <= hit_key;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_level;
            if (r_sync2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_db_level <= r_sync2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_press   = r_db_level & ~r_db_prev;
    assign w_entry   = (state != r_prev_state);
    assign w_is_mole = (state >= c_CODE_MOLE1) && (state <= c_CODE_MOLE4);

    always_comb begin
        w_score_inc = r_score;
        if (r_score == 8'h99) begin
            w_score_inc = 8'h99;
        end else if (r_score[3:0] == 4'd9) begin
            w_score_inc = {r_score[7:4] + 4'd1, 4'd0};
        end else begin
            w_score_inc = {r_score[7:4], r_score[3:0] + 4'd1};
        end
    end

    assign w_score_next = w_hit ? w_score_inc : r_score;

    always_comb begin
        w_fsm_next    = r_fsm;
        w_hit         = 1'b0;
        w_miss        = 1'b0;
        w_load_win    = 1'b0;
        w_clear_score = 1'b0;
        w_start_over  = 1'b0;
        case (r_fsm)
            c_IDLE: begin
                if (w_entry) begin
                    if (state == c_CODE_START) begin
                        w_clear_score = 1'b1;
                    end else if (w_is_mole) begin
                        w_load_win = 1'b1;
                        w_fsm_next = c_ARMED;
                    end else if (state == c_CODE_OVER) begin
                        w_start_over = 1'b1;
                        w_fsm_next   = c_OVER_WR;
                    end
                end
            end
            c_ARMED: begin
                // A press wins over both the timeout and a screen change.
                if (w_press) begin
                    w_hit      = 1'b1;
                    w_fsm_next = c_WRITE;
                end else if ((state != r_mole_code) || (r_win_cnt == '0)) begin
                    w_miss     = 1'b1;
                    w_fsm_next = c_WRITE;
                end
            end
            c_WRITE:   w_fsm_next = c_DONE;
            c_DONE:    w_fsm_next = c_IDLE;
            c_OVER_WR: w_fsm_next = c_IDLE;
            default:   w_fsm_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm        <= c_IDLE;
            r_prev_state <= 3'b000;
            r_mole_code  <= 3'b000;
            r_win_cnt    <= '0;
            r_score      <= 8'h00;
            r_top_score  <= 8'h00;
            r_mem_addr   <= 5'd0;
            r_mem_data   <= 8'h00;
        end else begin
            r_fsm        <= w_fsm_next;
            r_prev_state <= state;
            if (w_load_win) begin
                r_win_cnt   <= c_WIN_LOAD;
                r_mole_code <= state;
            end else if ((r_fsm == c_ARMED) && (r_win_cnt != '0)) begin
                r_win_cnt <= r_win_cnt - 1'b1;
            end
            if (w_clear_score) begin
                r_score <= 8'h00;
            end else begin
                r_score <= w_score_next;
            end
            // Packed BCD orders correctly under a plain unsigned compare.
            if ((r_fsm == c_WRITE) && (r_score > r_top_score)) begin
                r_top_score <= r_score;
            end
            if (w_hit || w_miss) begin
                r_mem_addr <= 5'd0;
                r_mem_data <= w_score_next;
            end else if (w_start_over) begin
                r_mem_addr <= 5'd1;
                r_mem_data <= r_top_score;
            end
        end
    end

    assign score      = r_score;
    assign top_score  = r_top_score;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign mem_wren   = ~reset & ((r_fsm == c_WRITE) || (r_fsm == c_OVER_WR));
    assign hit_pulse  = ~reset & w_hit;
    assign miss_pulse = ~reset & w_miss;
    assign mole_done  = ~reset & (r_fsm == c_DONE);

endmodule
`default_nettype wire

// File: doc/whack_scorer.md
Name: whack_scorer

Overview:
- Scoring stage between GameFSM and game_mem: watches the FSM state code and the player hit key, and decides hit or miss for each mole appearance.
- Keeps a 2-digit BCD score and top score, and issues single-cycle write transactions to game_mem (address/data/wren).
- Pulses mole_done back to the FSM so it can return from a mole screen to the game screen.
- hit_pulse / miss_pulse drive the audio tone select.

Parameters:
- WINDOW_CYCLES, 50000000: reaction window per mole in clk cycles (1 s at 50 MHz); legal range 2 to 2^26.
- DEBOUNCE_CYCLES, 500000: cycles the synchronised key must differ from the debounced level before that level flips; must be at least 1.

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high reset
- state  in  3  FSM state code: Start=000, Game=001, Mole1..Mole4=010..101, GameOver=110
- hit_key  in  1  raw player key, active-high (~KEY[1]), asynchronous to clk
- score  out  8  current score, packed BCD {tens,ones}
- top_score  out  8  best score since reset, packed BCD
- mem_addr  out  5  game_mem address
- mem_data  out  8  game_mem write data
- mem_wren  out  1  game_mem write enable, one-cycle pulse
- hit_pulse  out  1  one-cycle pulse on a scored hit
- miss_pulse  out  1  one-cycle pulse on a miss
- mole_done  out  1  one-cycle pulse to the FSM once a mole is resolved and written

Behaviour:
- Reset value of every output is 0. Reset also clears the debounce/sync registers and the window counter, sets prev_state to 000, and puts the FSM in IDLE.
- Reset overrides everything in the same cycle, including a reset asserted mid-ARMED or mid-WRITE; no write or pulse is issued afterwards.
- Key path:
  - 2-flop synchroniser, then a debounce counter.
  - The counter resets whenever the synchronised value equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips.
  - press = one-cycle pulse on a debounced 0->1 edge. Holding the key produces exactly one press.
- The state code is registered each cycle into prev_state. "Entry into X" means state==X and prev_state!=X.
- Internal FSM states: IDLE, ARMED, WRITE, DONE, OVER_WR.
  - IDLE:
    - Entry into Start clears score to 00 (top_score is kept).
    - Entry into any Mole code loads window counter = WINDOW_CYCLES-1 and goes to ARMED.
    - Entry into GameOver goes to OVER_WR.
    - A press in IDLE is ignored.
  - ARMED: the window counter decrements each cycle.
    - Press goes to WRITE with a hit: score increments in BCD (ones 9 -> 0 with tens+1; 99 saturates and stays 99), and hit_pulse=1 for this transition cycle.
    - Counter==0 with no press is a miss: score unchanged, miss_pulse=1, go to WRITE.
    - Press and counter==0 in the same cycle count as a hit.
    - State leaving the mole code, or changing to a different mole code, while ARMED is a miss. A change to a different mole code is not re-armed; that mole is treated as already entered.
  - WRITE: mem_wren=1, mem_addr=00000, mem_data = the updated score. If score > top_score, top_score <= score in the same cycle. Next state DONE.
  - DONE: mole_done=1 for one cycle, then IDLE.
  - OVER_WR: mem_wren=1, mem_addr=00001, mem_data=top_score, for one cycle; then IDLE. Fires once per GameOver entry.
- Latency:
  - Debounced press to hit_pulse: 1 cycle.
  - hit_pulse to mem_wren: 1 cycle.
  - mem_wren to mole_done: 1 cycle.
  - mem_wren never asserts on two consecutive cycles.
- BCD compare is a plain 8-bit unsigned compare, which is valid for packed BCD.
- mem_addr and mem_data hold their last values when mem_wren=0.

Test Plan (WINDOW_CYCLES=8, DEBOUNCE_CYCLES=2):
- Reset held 3 cycles during ARMED with hit_key high -> all outputs 0, no mem_wren for 20 cycles after release while state=001.
- state 001->010, hit_key high 10 cycles at window cycle 3 -> exactly one hit_pulse; mem_wren with addr 0, data 0x01 one cycle later; mole_done next cycle; score=0x01.
- state 001->011, no key -> miss_pulse exactly 8 cycles after entry; mem_wren data 0x00; score unchanged; no hit_pulse.
- Preload score 0x09 and hit -> score 0x10; preload 0x99 and hit -> score stays 0x99, hit_pulse and mem_wren still issued.
- Debounced press landing on the counter==0 cycle -> hit_pulse only, score +1; a 1-cycle glitch on hit_key -> no press, no hit.
- Hits reaching score 0x03, then state->110 -> top_score=0x03 and one write addr 00001 data 0x03; then state->000 -> score 0x00, top_score still 0x03.
